hex_display_scanner: RTL
========================

# hex_display_scanner

Time-multiplexed driver for a multi-digit common-anode seven-segment display. Holds a frame of hex digits, scans them one at a time, and presents the active digit's 4-bit code to the `sevenSegment_bitwise` decoder (`B`) together with an active-low digit-select bus. It sits directly upstream of the decoder. Anti-ghosting dead time, tear-free frame updates and optional leading-zero blanking are included.

## Interface
- `N_DIGITS`, 4, number of digits scanned (legal 1..8)
- `PRESCALE`, 50000, clock cycles a digit is lit per visit (>=1)
- `BLANK_CYCLES`, 500, dead-time cycles with all digits off before each digit (>=0)

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `value`  in  4*N_DIGITS  new frame; digit i = `value[4i+3:4i]`, digit 0 least significant
- `load`  in  1  one-cycle strobe capturing `value`
- `lz_en`  in  1  leading-zero blanking enable (sampled every cycle)
- `B`  out  4  hex code of current digit, to decoder
- `digit_n`  out  N_DIGITS  active-low digit select; at most one bit low
- `blank`  out  1  high when the downstream segment bus must be forced off
- `frame_done`  out  1  one-cycle pulse at end of each full scan

## Operation
- Registers: `pending` (4*N_DIGITS), `pending_valid`, `display` (4*N_DIGITS), digit index `idx` (clog2 N_DIGITS, min 1 bit), phase counter sized for max(PRESCALE, BLANK_CYCLES).
- FSM, two states:
  - DEAD: all `digit_n` = 1, `blank` = 1; stays BLANK_CYCLES cycles, then -> LIT. If BLANK_CYCLES = 0, DEAD is skipped (LIT -> LIT directly).
  - LIT: `digit_n[idx]` = 0, `B` = `display` nibble `idx`; stays PRESCALE cycles, then advances `idx` and -> DEAD.
- Scan order 0,1,...,N_DIGITS-1, wrap to 0. Leaving LIT with `idx` = N_DIGITS-1 is the frame wrap: `frame_done` pulses on that cycle's next edge.
- Load: `load` = 1 writes `value` to `pending`, sets `pending_valid`. At frame wrap, if `pending_valid`, `display` <= `pending`, `pending_valid` cleared. `display` never changes mid-frame.
- Simultaneous `load` and frame wrap: `value` goes straight to `display`; `pending_valid` ends 0.
- Repeated loads within a frame: last one wins.
- Leading-zero blanking (`lz_en` = 1): digit i > 0 is blanked when it and every higher digit in `display` are 0. Blanked digit: LIT phase still spent (constant brightness), `digit_n` all 1, `blank` = 1, `B` = 0. Digit 0 never blanked. `lz_en` = 0: no blanking.
- In LIT for a non-blanked digit, `blank` = 0.

## Timing
- Reset (async assert, sync release): state DEAD (or LIT if BLANK_CYCLES = 0), `idx` = 0, counters 0, `display` = 0, `pending` = 0, `pending_valid` = 0; outputs `B` = 0, `digit_n` = all 1, `blank` = 1, `frame_done` = 0.
- All outputs registered; no combinational path from inputs to outputs.
- First lit cycle after reset release: cycle BLANK_CYCLES+1 (digit 0).
- Digit period = PRESCALE + BLANK_CYCLES; frame period = N_DIGITS * (PRESCALE + BLANK_CYCLES).
- `frame_done` high exactly one cycle, coincident with the first cycle after the last LIT phase; updated `display` is visible on digit 0 of the next frame.
- Load latency to display: up to one frame; zero extra if coincident with wrap.
- Reset mid-frame: pending load discarded, scan restarts at digit 0.
- `digit_n` never has two bits low, including across state transitions.

## Test plan
- Reset then idle, N_DIGITS=4, PRESCALE=4, BLANK_CYCLES=2: `digit_n` = 1111 for 2 cycles, then 1110 for 4, 1111 for 2, 1101 for 4 ...; `B` = 0; `frame_done` every 24 cycles.
- `load` with `value` = 16'h3A7F mid-frame 0: frame 0 still shows 0s; next frame `B` = F,7,A,3 on digits 0..3.
- `load` of 16'h1234 on the exact wrap cycle: following frame shows 4,3,2,1 immediately; no further update at the next wrap.
- Two loads in one frame (16'h1111 then 16'h2222): next frame shows 2s only.
- `lz_en`=1, `display` = 16'h0050: digits 3,2 blanked (`blank`=1, `digit_n`=1111 during their LIT); digits 1 (5), 0 (0) lit. `display` = 0: only digit 0 lit showing 0.
- Assert `rst` during LIT of digit 2 with a pending load: outputs return immediately to reset values; after release digit 0 shows 0, pending value never appears.

Source files
------------

// File: rtl/hex_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : hex_display_scanner
// Description : Time-multiplexed scanner for a common-anode 7-segment display.
//               Holds a frame of hex digits, lights one digit at a time with
//               dead time in between, and updates the frame only at the wrap
//               between frames. Supports optional leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_display_scanner #(
  parameter int N_DIGITS     = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic                  load,
  input  logic                  lz_en,
  output logic [3:0]            B,
  output logic [N_DIGITS-1:0]   digit_n,
  output logic                  blank,
  output logic                  frame_done
);

  localparam int c_idx_w   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int c_cnt_max = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

  localparam logic [c_cnt_w-1:0] c_pre_last = c_cnt_w'(PRESCALE - 1);
  localparam logic [c_cnt_w-1:0] c_blk_last = c_cnt_w'(BLANK_CYCLES - 1);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(N_DIGITS - 1);

  typedef enum logic [0:0] {
    ST_DEAD = 1'b0,
    ST_LIT  = 1'b1
  } state_t;

  // With no dead time the scanner lives permanently in LIT.
  localparam state_t c_state_rst = (BLANK_CYCLES == 0) ? ST_LIT : ST_DEAD;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [c_cnt_w-1:0]      r_cnt;
  logic [c_cnt_w-1:0]      w_cnt_nxt;
  logic [c_idx_w-1:0]      r_idx;
  logic [c_idx_w-1:0]      w_idx_nxt;
  logic                    w_wrap;
  logic [4*N_DIGITS-1:0]   r_pending;
  logic                    r_pending_valid;
  logic [4*N_DIGITS-1:0]   r_display;
  logic [4*N_DIGITS-1:0]   w_display_nxt;
  logic                    w_lit;
  logic [3:0]              w_b_nxt;
  logic [N_DIGITS-1:0]     w_digit_n_nxt;

  // True when digit i is above digit 0 and it and every higher digit are zero.
  function automatic logic lz_blanked(input logic [4*N_DIGITS-1:0] disp,
                                      input logic [c_idx_w-1:0]    i);
    logic zero_above;
    zero_above = 1'b1;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (d >= int'(i) && disp[4*d +: 4] != 4'h0) zero_above = 1'b0;
    end
    return (i != '0) && zero_above;
  endfunction

  // State, phase counter and digit index register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_state_rst;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state logic: count out DEAD and LIT phases, advance digit on LIT exit.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_wrap      = 1'b0;
    case (r_state)
      ST_DEAD: begin
        if (r_cnt == c_blk_last) begin
          w_state_nxt = ST_LIT;
          w_cnt_nxt   = '0;
        end
      end
      ST_LIT: begin
        if (r_cnt == c_pre_last) begin
          w_cnt_nxt   = '0;
          w_wrap      = (r_idx == c_idx_last);
          w_idx_nxt   = w_wrap ? '0 : r_idx + 1'b1;
          w_state_nxt = (BLANK_CYCLES == 0) ? ST_LIT : ST_DEAD;
        end
      end
      default: begin
        w_state_nxt = c_state_rst;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Frame double-buffer: a load lands in pending; display only changes at wrap.
  // A load coincident with the wrap bypasses pending straight into display.
  always_comb begin
    w_display_nxt = r_display;
    if (w_wrap) begin
      if (load)                 w_display_nxt = value;
      else if (r_pending_valid) w_display_nxt = r_pending;
    end
  end

  // Pending / display buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending       <= '0;
      r_pending_valid <= 1'b0;
      r_display       <= '0;
    end else begin
      r_display <= w_display_nxt;
      if (w_wrap) begin
        r_pending_valid <= 1'b0;
      end else if (load) begin
        r_pending       <= value;
        r_pending_valid <= 1'b1;
      end
    end
  end

  // Output values for the upcoming cycle, derived from next state so the
  // registered outputs line up with the state they describe.
  always_comb begin
    w_lit = (w_state_nxt == ST_LIT) && !(lz_en && lz_blanked(w_display_nxt, w_idx_nxt));
    w_b_nxt = 4'h0;
    if (w_lit) w_b_nxt = w_display_nxt[{w_idx_nxt, 2'b00} +: 4];
    for (int d = 0; d < N_DIGITS; d++) begin
      w_digit_n_nxt[d] = !(w_lit && (w_idx_nxt == c_idx_w'(d)));
    end
  end

  // Registered outputs; at most one digit select can be low by construction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      B          <= 4'h0;
      digit_n    <= '1;
      blank      <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      B          <= w_b_nxt;
      digit_n    <= w_digit_n_nxt;
      blank      <= !w_lit;
      frame_done <= w_wrap;
    end
  end

endmodule
`default_nettype wire
